// File: rtl/apb_mem_slave_p.sv
// Parametrised APB slave memory with byte strobes, per-transfer wait states and PSLVERR.
// Optional APB_WR_PROTECT_EN: word DEPTH-1 bit0 locks writes to all other words.
module apb_mem_slave_p #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned WAIT_W = 4
) (
    input  logic                  apb_clk,
    input  logic                  sys_reset,
    input  logic                  apb_selx,
    input  logic                  apb_en,
    input  logic                  apb_write,
    input  logic [ADDR_W-1:0]     apb_addr,
    input  logic [DATA_W-1:0]     apb_wdata,
    input  logic [DATA_W/8-1:0]   apb_strb,
    input  logic [WAIT_W-1:0]     wait_cycle,
    output logic [DATA_W-1:0]     apb_rdata,
    output logic                  apb_ready,
    output logic                  apb_slverr
);

    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CMP_W = (ADDR_W > 32) ? ADDR_W : 32;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic [IDX_W-1:0]    idx;
    logic                addr_err;
    logic                wr_blocked;
    logic                xfer_err;
    logic                complete;
    logic                wr_commit;

    // Full-width compare so out-of-range indices never alias onto stored words.
    assign idx      = apb_addr[IDX_W-1:0];
    assign addr_err = CMP_W'(apb_addr) >= CMP_W'(DEPTH);
    assign complete = (state_q == ACCESS) && apb_selx && apb_en && (cnt_q == '0);

`ifdef APB_WR_PROTECT_EN
    assign wr_blocked = apb_write && mem_q[DEPTH-1][0]
                        && (CMP_W'(apb_addr) != CMP_W'(DEPTH - 1));
`else
    assign wr_blocked = 1'b0;
`endif

    assign xfer_err  = addr_err || wr_blocked;
    assign wr_commit = complete && apb_write && !xfer_err;

    always_ff @(posedge apb_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (apb_selx) begin
                    cnt_d   = wait_cycle;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!apb_selx) begin
                    state_d = IDLE;
                end else if (apb_en) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - WAIT_W'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        apb_ready  = complete;
        apb_slverr = complete && xfer_err;
        apb_rdata  = '0;
        if (complete && !apb_write && !addr_err) begin
            apb_rdata = mem_q[idx];
        end
    end

    always_ff @(posedge apb_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            for (int unsigned w = 0; w < DEPTH; w++) begin
                mem_q[w] <= '0;
            end
        end else if (wr_commit) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (apb_strb[i]) begin
                    mem_q[idx][8*i +: 8] <= apb_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
